seq_playback_ctrl: RTL and testbench
====================================

Name: seq_playback_ctrl

Overview:
- Reads the stored random-digit sequence back out of the RAM read port and presents it on the random-number display, one digit at a time, timed from the 100 ms pulse.
- Sits between the RAM read port (address out, q in) and decoder_4to7 for the random-number display.
- The game controller starts it after the sequencer finishes, and receives done when playback ends.
- Sequence length depends on the latched difficulty level.

Parameters:
ADDR_W, 5, RAM address width.
SHOW_TICKS, 10, number of tick pulses each digit is shown (10 x 100 ms = 1 s).
GAP_TICKS, 3, number of tick pulses of blank display between digits.
LEN0, 4, sequence length for diff=00.
LEN1, 8, sequence length for diff=01.
LEN2, 16, sequence length for diff=10.
LEN3, 32, sequence length for diff=11 (must be <= 2^ADDR_W).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous active-high reset.
start  input  1  single-cycle pulse (button-shaped or controller-issued) that begins playback.
abort  input  1  level; forces return to IDLE (used on logout/timeout).
diff  input  2  difficulty level; sampled only on an accepted start.
tick  input  1  single-cycle 100 ms pulse from the timer block.
ram_q  input  4  RAM read data; valid one clk after ram_addr is presented.
ram_addr  output  ADDR_W  RAM read address.
disp_digit  output  4  digit to the display decoder.
disp_blank  output  1  1 = display must be blanked.
tick_en  output  1  enable for the timer block; high whenever busy.
busy  output  1  high from the cycle after an accepted start until DONE.
done  output  1  single-cycle pulse when the last gap completes.

Behaviour:
- Reset (async, any state): state=IDLE, ram_addr=0, disp_digit=0, disp_blank=1, busy=0, tick_en=0, done=0, internal counters=0.
- Latched on accepted start: len is selected from LEN0..LEN3 by diff.
- Counter widths:
  - idx is ADDR_W+1 bits, so that a length of 32 is representable.
  - tcnt is wide enough for max(SHOW_TICKS, GAP_TICKS).
- State IDLE:
  - start=1 and abort=0 -> FETCH; latch len; idx=0; ram_addr=0.
  - All other inputs are ignored.
- State FETCH: drive ram_addr=idx[ADDR_W-1:0]; -> WAIT next cycle.
- State WAIT: the RAM latency cycle. Register disp_digit<=ram_q at the end of this cycle; disp_blank<=0; tcnt=0; -> SHOW.
- State SHOW:
  - On each tick, tcnt++.
  - When a tick arrives with tcnt==SHOW_TICKS-1: disp_blank<=1; tcnt=0; -> GAP.
  - disp_digit holds its value while in SHOW.
- State GAP:
  - On each tick, tcnt++.
  - When a tick arrives with tcnt==GAP_TICKS-1: idx++.
    - If idx+1==len -> DONE.
    - Otherwise -> FETCH.
- State DONE: done=1 for exactly one cycle; busy=0; disp_blank=1; -> IDLE.
- Tick counting:
  - A tick in the same cycle the FSM enters SHOW or GAP is not counted. Counting starts the cycle after entry.
  - Ticks in IDLE, FETCH, WAIT and DONE are ignored.
- abort:
  - abort=1 in any non-IDLE state -> IDLE on the next edge; disp_blank=1; busy=0; done is not asserted.
  - abort has priority over every other transition, including the final GAP tick.
- start while busy is ignored; no restart and no relatch of diff.
- start and abort in the same cycle while in IDLE: stay in IDLE.
- tick_en=busy.
- All outputs are registered; no combinational path from input to output.
- Address wrap: ram_addr never exceeds len-1. With LEN3=32, the last address is 31 and idx reaches 32 only at the DONE transition.
- Playback latency from start to first visible digit: 3 clk (IDLE->FETCH->WAIT->SHOW; disp_blank falls on SHOW entry).

Test Plan:
1. Reset mid-SHOW (rst pulse asynchronous to clk) -> outputs return to reset values immediately; playback does not resume after rst deasserts.
2. diff=00, RAM preloaded 3,7,1,9 at addr 0..3, SHOW_TICKS=10, GAP_TICKS=3, tick every 4 clk -> disp_digit shows 3,7,1,9, each unblanked for exactly 10 ticks with 3 blank ticks between; addresses 0..3 issued once each; done pulses once 1 clk after the 4th gap; total 52 ticks.
3. diff=11, RAM addr k holds k mod 10 -> 32 digits played, last ram_addr=31, no address 0 reissued, done once.
4. abort raised during the 2nd digit's SHOW -> next edge IDLE, disp_blank=1, busy=0, no done pulse; a following start replays from addr 0.
5. start pulsed again during GAP with diff changed from 00 to 11 -> ignored; playback still ends after 4 digits.
6. tick coincident with the WAIT->SHOW transition -> not counted; the digit stays unblanked for 10 further ticks.

Source files
------------

// File: rtl/seq_playback_ctrl.sv
// Plays the stored digit sequence from RAM onto the random-number display.
// Each digit is shown for SHOW_TICKS ticks, then blanked for GAP_TICKS ticks.
module seq_playback_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int SHOW_TICKS = 10,
    parameter int GAP_TICKS  = 3,
    parameter int LEN0       = 4,
    parameter int LEN1       = 8,
    parameter int LEN2       = 16,
    parameter int LEN3       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        diff,
    input  logic              tick,
    input  logic [3:0]        ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        disp_digit,
    output logic              disp_blank,
    output logic              tick_en,
    output logic              busy,
    output logic              done
);

    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SHOW, S_GAP, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [TW-1:0]     r_tcnt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_len;
    logic [IW-1:0]     w_idx_inc;
    logic [IW-1:0]     w_len_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_digit;
    logic              r_blank;
    logic              r_busy;
    logic              r_done;
    logic              w_show_end;
    logic              w_gap_end;
    logic              w_busy_nxt;

    assign w_idx_inc  = r_idx + 1'b1;
    assign w_show_end = tick && (r_tcnt == TW'(SHOW_TICKS - 1));
    assign w_gap_end  = tick && (r_tcnt == TW'(GAP_TICKS - 1));
    assign w_busy_nxt = (w_nxt == S_FETCH) || (w_nxt == S_WAIT) ||
                        (w_nxt == S_SHOW)  || (w_nxt == S_GAP);

    always_comb begin
        w_len_sel = IW'(LEN0);
        unique case (diff)
            2'd0: w_len_sel = IW'(LEN0);
            2'd1: w_len_sel = IW'(LEN1);
            2'd2: w_len_sel = IW'(LEN2);
            2'd3: w_len_sel = IW'(LEN3);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // abort outranks every transition out of a busy state
    always_comb begin
        w_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (start && !abort) begin
                w_nxt = S_FETCH;
            end
        end else if (abort) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_FETCH: w_nxt = S_WAIT;
                S_WAIT:  w_nxt = S_SHOW;
                S_SHOW:  if (w_show_end) w_nxt = S_GAP;
                S_GAP: begin
                    if (w_gap_end) begin
                        w_nxt = (w_idx_inc == r_len) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt  <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_digit <= '0;
            r_blank <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= (w_nxt == S_DONE);
            if (w_nxt == S_IDLE || w_nxt == S_DONE) begin
                r_blank <= 1'b1;
                r_tcnt  <= '0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_nxt == S_FETCH) begin
                        r_len  <= w_len_sel;
                        r_idx  <= '0;
                        r_addr <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_nxt == S_SHOW) begin
                        r_digit <= ram_q;
                        r_blank <= 1'b0;
                        r_tcnt  <= '0;
                    end
                end
                S_SHOW: begin
                    if (w_nxt == S_GAP) begin
                        r_blank <= 1'b1;
                        r_tcnt  <= '0;
                    end else if (w_nxt == S_SHOW && tick) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_nxt == S_FETCH) begin
                        r_idx  <= w_idx_inc;
                        r_addr <= w_idx_inc[ADDR_W-1:0];
                        r_tcnt <= '0;
                    end else if (w_nxt == S_DONE) begin
                        r_idx <= w_idx_inc;
                    end else if (w_nxt == S_GAP && tick) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr   = r_addr;
    assign disp_digit = r_digit;
    assign disp_blank = r_blank;
    assign busy       = r_busy;
    assign tick_en    = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Scoreboard bench for seq_playback_ctrl: stimulus queues expected digits,
// a negedge monitor pops them as the display unblanks and as done pulses.
module tb_seq_playback_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] diff;
    logic       tick;
    logic [3:0] ram_q;
    logic [4:0] ram_addr;
    logic [3:0] disp_digit;
    logic       disp_blank;
    logic       tick_en;
    logic       busy;
    logic       done;

    seq_playback_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .diff       (diff),
        .tick       (tick),
        .ram_q      (ram_q),
        .ram_addr   (ram_addr),
        .disp_digit (disp_digit),
        .disp_blank (disp_blank),
        .tick_en    (tick_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [32];
    always @(posedge clk) ram_q <= mem[ram_addr];

    typedef struct {
        bit         is_done;
        logic [3:0] dig;
        logic [4:0] addr;
    } item_t;

    item_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    tick_auto;
    int    tph;
    int    nbt;
    bit    prev_bt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor
    bit pb = 1'b1;
    int shown = 0;
    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            pb = 1'b1;
        end else begin
            if (pb && !disp_blank) begin
                shown = int'(tick);
                if (exp_q.size() == 0) begin
                    chk("unexpected_digit", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("digit_kind", 32'(it.is_done), 0);
                    chk("digit_val", disp_digit, it.dig);
                    chk("digit_addr", ram_addr, it.addr);
                end
            end else if (!disp_blank && tick) begin
                shown++;
            end
            if (!pb && disp_blank && busy) chk("show_ticks", shown, 10);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("done_kind", 32'(it.is_done), 1);
                end
                chk("done_busy", busy, 0);
                chk("done_blank", disp_blank, 1);
            end
            pb = disp_blank;
        end
    end

    task automatic cyc(input bit ft = 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        tick  = ft | (tick_auto && tph == 0);
        tph   = (tph + 1) % 4;
        if (busy && tick) nbt++;
    endtask

    task automatic push_seq(input int n);
        item_t it;
        for (int k = 0; k < n; k++) begin
            it.is_done = 1'b0;
            it.dig     = mem[k];
            it.addr    = 5'(k);
            exp_q.push_back(it);
        end
    endtask

    task automatic push_done();
        item_t it;
        it.is_done = 1'b1;
        it.dig     = '0;
        it.addr    = '0;
        exp_q.push_back(it);
    endtask

    // start one cycle after a tick so no tick lands in FETCH/WAIT
    task automatic go(input logic [1:0] d);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (tick) break;
        end
        cyc();
        start = 1'b1;
        diff  = d;
        nbt   = 0;
    endtask

    task automatic run_done(input int budget);
        bit got = 1'b0;
        prev_bt = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bit bt;
            cyc();
            bt = busy && tick;
            if (done) begin
                got = 1'b1;
                chk("done_after_gap_tick", 32'(prev_bt), 1);
                break;
            end
            prev_bt = bt;
        end
        chk("done_timeout", 32'(got), 1);
    endtask

    task automatic load_short();
        logic [3:0] v [4];
        v = '{4'd3, 4'd7, 4'd1, 4'd9};
        for (int k = 0; k < 4; k++) mem[k] = v[k];
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; diff = 2'd0; tick = 1'b0;
        tick_auto = 1'b1; tph = 0; nbt = 0;
        for (int k = 0; k < 32; k++) mem[k] = 4'(k % 10);
        load_short();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", ram_addr, 0);
        chk("rst_digit", disp_digit, 0);
        chk("rst_blank", disp_blank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tick_en", tick_en, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // asynchronous reset mid-SHOW
        push_seq(1);
        go(2'd0);
        for (int i = 0; i < 100 && disp_blank; i++) cyc();
        chk("t1_unblank", disp_blank, 0);
        repeat (8) cyc();
        #3 rst = 1'b1;
        #1;
        chk("t1_async_blank", disp_blank, 1);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_digit", disp_digit, 0);
        chk("t1_async_addr", ram_addr, 0);
        #2 rst = 1'b0;
        repeat (100) cyc();
        chk("t1_no_resume", busy, 0);
        chk("t1_queue", exp_q.size(), 0);

        // diff=00 full playback
        push_seq(4);
        push_done();
        go(2'd0);
        cyc();
        chk("t2_busy", busy, 1);
        chk("t2_tick_en", tick_en, 1);
        run_done(400);
        chk("t2_total_ticks", nbt, 52);
        chk("t2_last_addr", ram_addr, 3);
        repeat (40) cyc();
        chk("t2_queue", exp_q.size(), 0);

        // diff=11, 32 digits
        for (int k = 0; k < 32; k++) mem[k] = 4'(k % 10);
        push_seq(32);
        push_done();
        go(2'd3);
        run_done(3000);
        chk("t3_last_addr", ram_addr, 31);
        chk("t3_total_ticks", nbt, 416);
        repeat (40) cyc();
        chk("t3_queue", exp_q.size(), 0);
        chk("t3_addr_hold", ram_addr, 31);

        // abort during second digit
        load_short();
        push_seq(2);
        go(2'd0);
        for (int i = 0; i < 200 && !(!disp_blank && ram_addr == 5'd1); i++) cyc();
        chk("t4_second", ram_addr, 1);
        repeat (5) cyc();
        cyc();
        abort = 1'b1;
        cyc();
        chk("t4_abort_blank", disp_blank, 1);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        repeat (60) cyc();
        chk("t4_queue", exp_q.size(), 0);
        push_seq(4);
        push_done();
        go(2'd0);
        run_done(400);
        repeat (10) cyc();
        chk("t4_replay_queue", exp_q.size(), 0);

        // start with diff=11 during GAP is ignored
        push_seq(4);
        push_done();
        go(2'd0);
        for (int i = 0; i < 100 && disp_blank; i++) cyc();
        for (int i = 0; i < 100 && !(disp_blank && busy); i++) cyc();
        chk("t5_in_gap", disp_blank, 1);
        cyc();
        start = 1'b1;
        diff  = 2'd3;
        run_done(400);
        chk("t5_total_ticks", nbt, 52);
        repeat (10) cyc();
        chk("t5_queue", exp_q.size(), 0);

        // tick coincident with WAIT->SHOW is not counted
        push_seq(4);
        push_done();
        tick_auto = 1'b0;
        cyc();
        start = 1'b1;
        diff  = 2'd0;
        nbt   = 0;
        cyc();
        cyc(1'b1);
        chk("t6_wait_blank", disp_blank, 1);
        chk("t6_wait_busy", busy, 1);
        tick_auto = 1'b1;
        tph = 1;
        run_done(400);
        chk("t6_total_ticks", nbt, 53);
        repeat (10) cyc();
        chk("t6_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
